// File: rtl/sint_test_pkg.sv
// Shared helpers for the signed-integer fixture: range masks
// and a sign-extending add that reports signed overflow.
package sint_test_pkg;

    // Widest data width the helpers can represent (need WIDTH <= MAX_W-2).
    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic  ovf;
        wide_t sum;
    } add_res_t;

    // Most-negative value of a width-bit signed number, zero-padded.
    function automatic wide_t sint_min(input int width);
        wide_t m;
        m = '0;
        m[width-1] = 1'b1;
        return m;
    endfunction

    // Most-positive value of a width-bit signed number, zero-padded.
    function automatic wide_t sint_max(input int width);
        wide_t m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width - 1) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Replicate bit width-1 of v into every higher bit.
    function automatic wide_t sext(input wide_t v, input int width);
        wide_t r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < width) ? v[i] : v[width-1];
        end
        return r;
    endfunction

    // Signed add of two width-bit values; bit width of the sum is the
    // true sign, so a disagreement with bit width-1 means overflow.
    function automatic add_res_t sext_add(input wide_t a, input wide_t b,
                                          input int width);
        add_res_t res;
        wide_t    s;
        s = sext(a, width) + sext(b, width);
        res.sum = s;
        res.ovf = (s[width] != s[width-1]);
        return res;
    endfunction

endpackage

// File: rtl/sint_delay_line.sv
// Fixed-latency shift register carrying a valid bit and data;
// every stage clears on reset.
module sint_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; stage 0 captures d unconditionally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sint_accum_test.sv
// Signed-value fixture: DEPTH-cycle delay line, saturating or
// wrapping accumulator with sticky overflow, and sample counter.
module sint_accum_test
    import sint_test_pkg::*;
#(
    parameter int WIDTH    = 33,
    parameter int DEPTH    = 2,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out_const_min,
    output logic [WIDTH-1:0] out_const_max
);

    localparam wide_t            MIN_F = sint_min(WIDTH);
    localparam wide_t            MAX_F = sint_max(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V = MIN_F[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_V = MAX_F[WIDTH-1:0];

    logic [WIDTH:0]   dl_q;
    add_res_t         add_r;
    logic [WIDTH-1:0] acc_next;
    logic             unused_sum;

    assign out_const_min = MIN_V;
    assign out_const_max = MAX_V;

    sint_delay_line #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .d       ({in_valid, in}),
        .q       (dl_q)
    );

    assign {out_valid, out} = dl_q;

    // Bits above the sign position carry no information.
    assign unused_sum = ^add_r.sum[MAX_W-1:WIDTH+1];

    // Next accumulator value: in-range sum, clamp, or wrapped sum.
    always_comb begin
        add_r    = sext_add(MAX_W'(acc), MAX_W'(in), WIDTH);
        acc_next = add_r.sum[WIDTH-1:0];
        if (add_r.ovf && (SATURATE != 0)) begin
            acc_next = add_r.sum[WIDTH] ? MIN_V : MAX_V;
        end
    end

    // Accumulate qualified samples; clear wins over a same-cycle sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (clear) begin
            acc      <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (in_valid) begin
            acc   <= acc_next;
            count <= count + CNT_W'(1);
            if (add_r.ovf) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sint_accum_test.sv
// Randomized bench for sint_accum_test: three parameterisations
// checked each cycle against an arithmetic reference model.
module tb_sint_accum_test;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in8;
    logic [32:0] in33;
    logic        in_valid;
    logic        clear;

    logic [7:0]  out_s, acc_s, min_s, max_s;
    logic        ov_s, ovf_s;
    logic [3:0]  cnt_s;
    logic [7:0]  out_w, acc_w, min_w, max_w;
    logic        ov_w, ovf_w;
    logic [15:0] cnt_w;
    logic [32:0] out_l, acc_l, min_l, max_l;
    logic        ov_l, ovf_l;
    logic [15:0] cnt_l;

    sint_accum_test #(.WIDTH(8), .DEPTH(DEPTH), .SATURATE(1), .CNT_W(4)) dut_s (
        .clock(clock), .reset_n(reset_n), .in(in8), .in_valid(in_valid),
        .clear(clear), .out(out_s), .out_valid(ov_s), .acc(acc_s),
        .overflow(ovf_s), .count(cnt_s), .out_const_min(min_s),
        .out_const_max(max_s)
    );

    sint_accum_test #(.WIDTH(8), .DEPTH(DEPTH), .SATURATE(0), .CNT_W(16)) dut_w (
        .clock(clock), .reset_n(reset_n), .in(in8), .in_valid(in_valid),
        .clear(clear), .out(out_w), .out_valid(ov_w), .acc(acc_w),
        .overflow(ovf_w), .count(cnt_w), .out_const_min(min_w),
        .out_const_max(max_w)
    );

    sint_accum_test #(.WIDTH(33), .DEPTH(DEPTH), .SATURATE(1), .CNT_W(16)) dut_l (
        .clock(clock), .reset_n(reset_n), .in(in33), .in_valid(in_valid),
        .clear(clear), .out(out_l), .out_valid(ov_l), .acc(acc_l),
        .overflow(ovf_l), .count(cnt_l), .out_const_min(min_l),
        .out_const_max(max_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic per instance.
    typedef struct {
        bit     v;
        longint d8;
        longint d33;
    } smp_t;

    smp_t   hist[$];
    int     m_w[3]   = '{8, 8, 33};
    int     m_sat[3] = '{1, 0, 1};
    int     m_cw[3]  = '{4, 16, 16};
    longint m_acc[3];
    bit     m_ovf[3];
    longint m_cnt[3];

    function automatic longint wrap(input longint s, input int w);
        longint m;
        longint r;
        m = longint'(1) <<< w;
        r = s % m;
        if (r >= m / 2) r = r - m;
        if (r < -(m / 2)) r = r + m;
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        longint x8, x33, x, s, hi, lo;
        smp_t   e;
        x8  = longint'($signed(in8));
        x33 = longint'($signed(in33));
        e.v   = in_valid;
        e.d8  = x8;
        e.d33 = x33;
        hist.push_back(e);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            x  = (i < 2) ? x8 : x33;
            hi = (longint'(1) <<< (m_w[i] - 1)) - 1;
            lo = -hi - 1;
            if (clear) begin
                m_acc[i] = 0;
                m_ovf[i] = 0;
                m_cnt[i] = 0;
            end else if (in_valid) begin
                s = m_acc[i] + x;
                if (s > hi || s < lo) begin
                    m_ovf[i] = 1;
                    if (m_sat[i] != 0) m_acc[i] = (s > hi) ? hi : lo;
                    else m_acc[i] = wrap(s, m_w[i]);
                end else begin
                    m_acc[i] = s;
                end
                m_cnt[i] = (m_cnt[i] + 1) % (longint'(1) <<< m_cw[i]);
            end
        end
    endtask

    task automatic cmp_inst(input int i, input string nm, input longint acc,
                            input bit ovf, input longint cnt,
                            input longint out, input bit ov);
        smp_t   e;
        longint eo;
        bit     ev;
        ev = 0;
        eo = 0;
        if (hist.size() == DEPTH) begin
            e  = hist[0];
            ev = e.v;
            eo = (i < 2) ? e.d8 : e.d33;
        end
        check({nm, "_acc"}, acc, m_acc[i]);
        check({nm, "_ovf"}, longint'(ovf), longint'(m_ovf[i]));
        check({nm, "_cnt"}, cnt, m_cnt[i]);
        check({nm, "_out"}, out, eo);
        check({nm, "_outv"}, longint'(ov), longint'(ev));
    endtask

    task automatic compare_all();
        cmp_inst(0, "sat8", longint'($signed(acc_s)), ovf_s, longint'(cnt_s),
                 longint'($signed(out_s)), ov_s);
        cmp_inst(1, "wrap8", longint'($signed(acc_w)), ovf_w, longint'(cnt_w),
                 longint'($signed(out_w)), ov_w);
        cmp_inst(2, "sat33", longint'($signed(acc_l)), ovf_l, longint'(cnt_l),
                 longint'($signed(out_l)), ov_l);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive8(input longint v);
        in8  = 8'(v);
        in33 = 33'(v);
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_acc_s", longint'(acc_s), 0);
        check("rst_cnt_s", longint'(cnt_s), 0);
        check("rst_ov_s", longint'(ov_s), 0);
        check("rst_acc_l", longint'(acc_l), 0);
        check("rst_cnt_w", longint'(cnt_w), 0);
        check("rst_ov_l", longint'(ov_l), 0);
        @(posedge clock);
        #1;
        compare_all();
        reset_n = 1'b1;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        in8      = '0;
        in33     = '0;
        in_valid = 1'b0;
        clear    = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        check("min8", longint'(min_s), 64'h80);
        check("max8", longint'(max_s), 64'h7F);
        check("min8w", longint'(max_w) + longint'(min_w), 64'hFF);
        check("min33", longint'(min_l), 64'h1_0000_0000);
        check("max33", longint'(max_l), 64'h0_FFFF_FFFF);
        reset_n = 1'b1;

        // Latency: -10 presented once, seen on out exactly two edges later.
        drive8(-10);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drive8(0);
        check("lat1_v", longint'(ov_s), 0);
        step();
        check("lat2_v", longint'(ov_s), 1);
        check("lat2_d", longint'(out_s), 64'hF6);
        step();
        check("lat3_v", longint'(ov_s), 0);

        // Saturate vs wrap on 100 + 50, then -128.
        clear = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b1;
        drive8(100);
        step();
        drive8(50);
        step();
        check("sat_acc", longint'($signed(acc_s)), 127);
        check("sat_ovf", longint'(ovf_s), 1);
        check("wrap_acc", longint'(acc_w), 64'h96);
        check("wrap_ovf", longint'(ovf_w), 1);
        drive8(-128);
        step();
        check("sat_back", longint'($signed(acc_s)), -1);
        check("sat_sticky", longint'(ovf_s), 1);

        // Clear beats a simultaneous sample.
        clear = 1'b1;
        drive8(5);
        step();
        clear = 1'b0;
        check("clr_acc", longint'(acc_w), 0);
        check("clr_ovf", longint'(ovf_w), 0);
        check("clr_cnt", longint'(cnt_w), 0);

        // 17 samples of +1 wrap a 4-bit counter to 1.
        drive8(1);
        repeat (17) step();
        check("cnt_wrap", longint'(cnt_s), 1);
        check("cnt_acc", longint'($signed(acc_s)), 17);

        // Random stream with occasional clears and one async reset.
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 7))
                0: in8 = 8'h80;
                1: in8 = 8'h7F;
                default: in8 = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: in33 = 33'h1_0000_0000;
                1: in33 = 33'h0_FFFF_FFFF;
                default: in33 = {1'($urandom_range(0, 1)), 32'($urandom)};
            endcase
            step();
            if (c == 200) mid_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
